// File: rtl/core_lsu_if.sv
// Memory-side bus of the load/store unit.
// Handshake: MEM_REQ with MEM_ADDR/MEM_WE/MEM_WSTRB/MEM_WDATA is held stable until the cycle
// MEM_GNT is high (request accepted); the response is the later cycle MEM_RVALID is high with MEM_RDATA.
interface core_lsu_if;
   logic        MEM_REQ;
   logic        MEM_WE;
   logic [31:0] MEM_ADDR;
   logic [3:0]  MEM_WSTRB;
   logic [31:0] MEM_WDATA;
   logic        MEM_GNT;
   logic        MEM_RVALID;
   logic [31:0] MEM_RDATA;

   modport master (
      output MEM_REQ, MEM_WE, MEM_ADDR, MEM_WSTRB, MEM_WDATA,
      input  MEM_GNT, MEM_RVALID, MEM_RDATA
   );

   modport slave (
      input  MEM_REQ, MEM_WE, MEM_ADDR, MEM_WSTRB, MEM_WDATA,
      output MEM_GNT, MEM_RVALID, MEM_RDATA
   );
endinterface

// File: rtl/core_lsu.sv
// Load/store unit: aligns store data onto the word bus, extracts and extends load data,
// and aborts accesses that are misaligned or exceed TIMEOUT_CYCLES waiting for a response.
module core_lsu #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        CLK,
   input  logic        NRST,
   input  logic        C_MEM,
   input  logic        IS_LOAD,
   input  logic        IS_STORE,
   input  logic [31:0] DMEM_ADDR,
   input  logic [3:0]  STRB,
   input  logic        ISLOADBS,
   input  logic        ISLOADHWS,
   input  logic [31:0] REG_RDATA2,
   core_lsu_if.master  mem,
   output logic [31:0] LOAD_DATA,
   output logic        DONE,
   output logic        BUSY,
   output logic        ERR,
   output logic [1:0]  dbg_state
);
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_RESP = 2'd2,
      S_DONE = 2'd3
   } state_e;

   state_e      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic        is_load_q, is_load_d;
   logic [1:0]  off_q, off_d;
   logic        sz_byte_q, sz_byte_d;
   logic        sz_half_q, sz_half_d;
   logic        sgn_b_q, sgn_b_d;
   logic        sgn_h_q, sgn_h_d;
   logic        mem_req_q, mem_req_d;
   logic        mem_we_q, mem_we_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [3:0]  mem_wstrb_q, mem_wstrb_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic [31:0] load_data_q, load_data_d;
   logic        done_q, done_d;
   logic        busy_q, busy_d;
   logic        err_q, err_d;

   logic [2:0]  pop;
   logic        is_byte, is_half, is_word;
   logic        has_access, access_err;
   logic [16:0] cnt_inc;
   logic        timeout_hit;
   logic [31:0] wdata_sh, rdata_sh, load_ext;

   assign pop        = 3'($countones(STRB));
   assign is_byte    = (pop == 3'd1);
   assign is_half    = (pop == 3'd2);
   assign is_word    = (pop == 3'd4);
   assign has_access = IS_LOAD | IS_STORE;

   // Access size comes from the strobe popcount; 0 or 3 lanes, or load+store together, are illegal.
   assign access_err = has_access &
                       ((IS_LOAD & IS_STORE) | ~(is_byte | is_half | is_word) |
                        (is_half & (DMEM_ADDR[1:0] == 2'b11)) |
                        (is_word & (DMEM_ADDR[1:0] != 2'b00)));

   assign cnt_inc     = {1'b0, cnt_q} + 17'd1;
   assign timeout_hit = (cnt_inc == 17'(TIMEOUT_CYCLES));

   assign wdata_sh = REG_RDATA2 << {DMEM_ADDR[1:0], 3'b000};
   assign rdata_sh = mem.MEM_RDATA >> {off_q, 3'b000};

   always_comb begin
      load_ext = rdata_sh;
      if (sz_byte_q) begin
         load_ext = {{24{sgn_b_q & rdata_sh[7]}}, rdata_sh[7:0]};
      end else if (sz_half_q) begin
         load_ext = {{16{sgn_h_q & rdata_sh[15]}}, rdata_sh[15:0]};
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      is_load_d   = is_load_q;
      off_d       = off_q;
      sz_byte_d   = sz_byte_q;
      sz_half_d   = sz_half_q;
      sgn_b_d     = sgn_b_q;
      sgn_h_d     = sgn_h_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wstrb_d = mem_wstrb_q;
      mem_wdata_d = mem_wdata_q;
      load_data_d = load_data_q;
      done_d      = 1'b0;
      err_d       = err_q;

      case (state_q)
         S_IDLE: begin
            if (C_MEM) begin
               err_d = 1'b0;
               if (has_access && !access_err) begin
                  state_d     = S_REQ;
                  cnt_d       = 16'd0;
                  mem_req_d   = 1'b1;
                  is_load_d   = IS_LOAD;
                  off_d       = DMEM_ADDR[1:0];
                  sz_byte_d   = is_byte;
                  sz_half_d   = is_half;
                  sgn_b_d     = ISLOADBS;
                  sgn_h_d     = ISLOADHWS;
                  mem_we_d    = IS_STORE;
                  mem_addr_d  = {DMEM_ADDR[31:2], 2'b00};
                  mem_wstrb_d = STRB;
                  mem_wdata_d = wdata_sh;
               end else begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
                  err_d   = access_err;
               end
            end
         end
         S_REQ: begin
            cnt_d = cnt_inc[15:0];
            // A grant on the timeout cycle loses: the access is already being abandoned.
            if (timeout_hit) begin
               state_d   = S_DONE;
               done_d    = 1'b1;
               err_d     = 1'b1;
               mem_req_d = 1'b0;
            end else if (mem.MEM_GNT) begin
               state_d   = S_RESP;
               mem_req_d = 1'b0;
            end
         end
         S_RESP: begin
            cnt_d = cnt_inc[15:0];
            if (mem.MEM_RVALID) begin
               state_d = S_DONE;
               done_d  = 1'b1;
               if (is_load_q) begin
                  load_data_d = load_ext;
               end
            end else if (timeout_hit) begin
               state_d = S_DONE;
               done_d  = 1'b1;
               err_d   = 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge CLK or negedge NRST) begin
      if (!NRST) begin
         state_q     <= S_IDLE;
         cnt_q       <= 16'd0;
         is_load_q   <= 1'b0;
         off_q       <= 2'd0;
         sz_byte_q   <= 1'b0;
         sz_half_q   <= 1'b0;
         sgn_b_q     <= 1'b0;
         sgn_h_q     <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= 32'd0;
         mem_wstrb_q <= 4'd0;
         mem_wdata_q <= 32'd0;
         load_data_q <= 32'd0;
         done_q      <= 1'b0;
         busy_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         is_load_q   <= is_load_d;
         off_q       <= off_d;
         sz_byte_q   <= sz_byte_d;
         sz_half_q   <= sz_half_d;
         sgn_b_q     <= sgn_b_d;
         sgn_h_q     <= sgn_h_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wstrb_q <= mem_wstrb_d;
         mem_wdata_q <= mem_wdata_d;
         load_data_q <= load_data_d;
         done_q      <= done_d;
         busy_q      <= busy_d;
         err_q       <= err_d;
      end
   end

   assign mem.MEM_REQ   = mem_req_q;
   assign mem.MEM_WE    = mem_we_q;
   assign mem.MEM_ADDR  = mem_addr_q;
   assign mem.MEM_WSTRB = mem_wstrb_q;
   assign mem.MEM_WDATA = mem_wdata_q;
   assign LOAD_DATA     = load_data_q;
   assign DONE          = done_q;
   assign BUSY          = busy_q;
   assign ERR           = err_q;
   assign dbg_state     = state_q;
endmodule

// File: tb/tb_core_lsu.sv
// Bench for core_lsu: directed vector table, randomized accesses against a lane/size model,
// and hand sequences for reset during an access.
module tb_core_lsu;
   localparam int TO = 4;

   logic        CLK = 1'b0;
   logic        NRST;
   logic        C_MEM, IS_LOAD, IS_STORE, ISLOADBS, ISLOADHWS;
   logic [31:0] DMEM_ADDR, REG_RDATA2, LOAD_DATA;
   logic [3:0]  STRB;
   logic        DONE, BUSY, ERR;
   logic [1:0]  dbg_state;

   core_lsu_if mem ();

   core_lsu #(.TIMEOUT_CYCLES(TO)) dut (
      .CLK(CLK), .NRST(NRST), .C_MEM(C_MEM), .IS_LOAD(IS_LOAD), .IS_STORE(IS_STORE),
      .DMEM_ADDR(DMEM_ADDR), .STRB(STRB), .ISLOADBS(ISLOADBS), .ISLOADHWS(ISLOADHWS),
      .REG_RDATA2(REG_RDATA2), .mem(mem), .LOAD_DATA(LOAD_DATA), .DONE(DONE),
      .BUSY(BUSY), .ERR(ERR), .dbg_state(dbg_state)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      bit          ld;
      bit          st;
      logic [31:0] addr;
      logic [3:0]  strb;
      bit          bs;
      bit          hws;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          gnt_wait;
      int          rv_wait;
      logic [31:0] exp_addr;
      logic [31:0] exp_wdata;
      logic [31:0] exp_load;
      bit          exp_err;
      int          exp_done;
      int          exp_req;
   } vec_t;

   vec_t        tbl[14];
   logic [31:0] exp_q[$];
   logic [31:0] cur_load;
   int          n_tests = 0;
   int          n_fail  = 0;
   bit          spam    = 1'b0;
   string       tag;

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s/%s: got %h expected %h", tag, name, act, exp);
      end
   endtask

   task automatic check_zero(input string pfx);
      check({pfx, "_load_data"}, LOAD_DATA, 32'd0);
      check({pfx, "_done"}, 32'(DONE), 32'd0);
      check({pfx, "_busy"}, 32'(BUSY), 32'd0);
      check({pfx, "_err"}, 32'(ERR), 32'd0);
      check({pfx, "_mem_req"}, 32'(mem.MEM_REQ), 32'd0);
      check({pfx, "_mem_we"}, 32'(mem.MEM_WE), 32'd0);
      check({pfx, "_mem_addr"}, mem.MEM_ADDR, 32'd0);
      check({pfx, "_mem_wstrb"}, 32'(mem.MEM_WSTRB), 32'd0);
      check({pfx, "_mem_wdata"}, mem.MEM_WDATA, 32'd0);
      check({pfx, "_state"}, 32'(dbg_state), 32'd0);
   endtask

   // Reference: lane/size/extension rules and cycle budget expressed with plain arithmetic.
   function automatic vec_t model(input vec_t v, input logic [31:0] prev);
      int          pop, off, total;
      logic [31:0] sh, res;
      pop = $countones(v.strb);
      off = int'(v.addr % 4);
      v.exp_load = prev; v.exp_req = 0; v.exp_addr = 0; v.exp_wdata = 0;
      if (!v.ld && !v.st) begin
         v.exp_err = 0; v.exp_done = 1;
      end else if (!(pop == 1 || pop == 2 || pop == 4) || (pop == 2 && off == 3) ||
                   (pop == 4 && off != 0)) begin
         v.exp_err = 1; v.exp_done = 1;
      end else begin
         v.exp_addr  = v.addr - 32'(off);
         v.exp_wdata = v.wdata << (8 * off);
         v.exp_req   = v.gnt_wait + 1;
         total = v.gnt_wait + 1 + v.rv_wait + 1;
         if (total > TO) begin
            v.exp_err = 1; v.exp_done = TO + 1;
         end else begin
            v.exp_err = 0; v.exp_done = total + 1;
            if (v.ld) begin
               sh = v.rdata >> (8 * off);
               if (pop == 1) begin
                  res = sh % 256;
                  if (v.bs && res >= 128) res = res + 32'hFFFF_FF00;
               end else if (pop == 2) begin
                  res = sh % 65536;
                  if (v.hws && res >= 32768) res = res + 32'hFFFF_0000;
               end else begin
                  res = sh;
               end
               v.exp_load = res;
            end
         end
      end
      return v;
   endfunction

   task automatic run_vec(input vec_t v);
      int          cyc, reqc, gnt_at, done_at;
      bit          granted, unstable, req_done;
      logic        err_at, we0;
      logic [31:0] ld_at, a0, wd0;
      logic [3:0]  ws0;
      reqc = 0; gnt_at = 0; done_at = -1; granted = 0; unstable = 0; req_done = 1;
      err_at = 1'bx; ld_at = 'x; a0 = 0; wd0 = 0; we0 = 0; ws0 = 0;
      exp_q.push_back(v.exp_load);
      IS_LOAD = v.ld; IS_STORE = v.st; DMEM_ADDR = v.addr; STRB = v.strb;
      ISLOADBS = v.bs; ISLOADHWS = v.hws; REG_RDATA2 = v.wdata; C_MEM = 1'b1;
      step();
      check("busy_c1", 32'(BUSY), 32'd1);
      cyc = 1;
      while (cyc < 40) begin
         C_MEM = 1'b0; mem.MEM_GNT = 1'b0; mem.MEM_RVALID = 1'b0; mem.MEM_RDATA = $urandom;
         if (DONE) begin
            done_at = cyc; err_at = ERR; ld_at = LOAD_DATA; req_done = mem.MEM_REQ;
            break;
         end
         if (mem.MEM_REQ) begin
            if (reqc == 0) begin
               a0 = mem.MEM_ADDR; we0 = mem.MEM_WE; ws0 = mem.MEM_WSTRB; wd0 = mem.MEM_WDATA;
            end else if (mem.MEM_ADDR !== a0 || mem.MEM_WE !== we0 ||
                         mem.MEM_WSTRB !== ws0 || mem.MEM_WDATA !== wd0) begin
               unstable = 1;
            end
            reqc++;
            if (reqc > v.gnt_wait) begin
               mem.MEM_GNT = 1'b1; granted = 1; gnt_at = cyc;
            end
            mem.MEM_RVALID = spam;
         end else if (granted && cyc > gnt_at + v.rv_wait) begin
            mem.MEM_RVALID = 1'b1; mem.MEM_RDATA = v.rdata;
         end
         if (spam) begin
            C_MEM = 1'b1; DMEM_ADDR = $urandom; STRB = 4'($urandom); REG_RDATA2 = $urandom;
            IS_LOAD = 1'($urandom); IS_STORE = 1'($urandom);
         end
         step();
         cyc++;
      end
      C_MEM = 1'b0; mem.MEM_GNT = 1'b0; mem.MEM_RVALID = 1'b0;
      check("done_cycle", 32'(done_at), 32'(v.exp_done));
      check("err", 32'(err_at), 32'(v.exp_err));
      check("load_data", ld_at, exp_q.pop_front());
      check("req_cycles", 32'(reqc), 32'(v.exp_req));
      check("req_at_done", 32'(req_done), 32'd0);
      if (v.exp_req > 0) begin
         check("mem_addr", a0, v.exp_addr);
         check("mem_we", 32'(we0), 32'(v.st));
         check("mem_wstrb", 32'(ws0), 32'(v.strb));
         check("mem_wdata", wd0, v.exp_wdata);
         check("req_stable", 32'(unstable), 32'd0);
      end
      step();
      check("done_pulse", 32'(DONE), 32'd0);
      check("idle_busy", 32'(BUSY), 32'd0);
      check("err_held", 32'(ERR), 32'(v.exp_err));
      check("load_held", LOAD_DATA, v.exp_load);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v;
      int   sel, done_seen;
      NRST = 1'b0; C_MEM = 0; IS_LOAD = 0; IS_STORE = 0; DMEM_ADDR = 0; STRB = 0;
      ISLOADBS = 0; ISLOADHWS = 0; REG_RDATA2 = 0;
      mem.MEM_GNT = 0; mem.MEM_RVALID = 0; mem.MEM_RDATA = 0;

      //          ld st addr          strb     bs hws wdata          rdata         gw rw exp_addr       exp_wdata      exp_load       err done req
      tbl[0]  = '{1, 0, 32'h0000_1002, 4'b0100, 1, 0, 32'h0,         32'h0080_0000, 0, 0, 32'h0000_1000, 32'h0,         32'hFFFF_FF80, 0, 3, 1};
      tbl[1]  = '{1, 0, 32'h0000_2002, 4'b1100, 0, 0, 32'h0,         32'hBEEF_1234, 0, 0, 32'h0000_2000, 32'h0,         32'h0000_BEEF, 0, 3, 1};
      tbl[2]  = '{0, 1, 32'h0000_3001, 4'b0010, 0, 0, 32'h0000_00AB, 32'h0,         0, 0, 32'h0000_3000, 32'h0000_AB00, 32'h0000_BEEF, 0, 3, 1};
      tbl[3]  = '{1, 0, 32'h0000_4001, 4'b1111, 0, 0, 32'h0,         32'h0,         0, 0, 32'h0,         32'h0,         32'h0000_BEEF, 1, 1, 0};
      tbl[4]  = '{1, 0, 32'h0000_5000, 4'b1111, 0, 0, 32'h0,         32'h1111_1111, 100, 0, 32'h0000_5000, 32'h0,       32'h0000_BEEF, 1, 5, 4};
      tbl[5]  = '{1, 0, 32'h0000_6000, 4'b0011, 0, 1, 32'h0,         32'h0000_8001, 1, 1, 32'h0000_6000, 32'h0,         32'hFFFF_8001, 0, 5, 2};
      tbl[6]  = '{1, 0, 32'h0000_7004, 4'b1111, 0, 0, 32'h0,         32'h1234_5678, 0, 0, 32'h0000_7004, 32'h0,         32'h1234_5678, 0, 3, 1};
      tbl[7]  = '{1, 0, 32'h0000_8003, 4'b1100, 0, 0, 32'h0,         32'h0,         0, 0, 32'h0,         32'h0,         32'h1234_5678, 1, 1, 0};
      tbl[8]  = '{0, 1, 32'h0000_8100, 4'b0111, 0, 0, 32'h0000_0055, 32'h0,         0, 0, 32'h0,         32'h0,         32'h1234_5678, 1, 1, 0};
      tbl[9]  = '{0, 0, 32'h0000_8200, 4'b0001, 0, 0, 32'h0,         32'h0,         0, 0, 32'h0,         32'h0,         32'h1234_5678, 0, 1, 0};
      tbl[10] = '{0, 1, 32'h0000_9000, 4'b1111, 0, 0, 32'hDEAD_BEEF, 32'h0,         0, 2, 32'h0000_9000, 32'hDEAD_BEEF, 32'h1234_5678, 0, 5, 1};
      tbl[11] = '{0, 1, 32'h0000_A002, 4'b1100, 0, 0, 32'h1234_CAFE, 32'h0,         2, 0, 32'h0000_A000, 32'hCAFE_0000, 32'h1234_5678, 0, 5, 3};
      tbl[12] = '{1, 0, 32'h0000_B003, 4'b1000, 0, 0, 32'h0,         32'h9A00_0000, 0, 0, 32'h0000_B000, 32'h0,         32'h0000_009A, 0, 3, 1};
      tbl[13] = '{1, 0, 32'h0000_C000, 4'b1111, 0, 0, 32'h0,         32'h7777_7777, 0, 3, 32'h0000_C000, 32'h0,         32'h0000_009A, 1, 5, 1};

      tag = "reset";
      step(); step();
      check_zero("rst");
      @(negedge CLK);
      NRST = 1'b1;

      for (int i = 0; i < 14; i++) begin
         tag = $sformatf("vec%0d", i);
         run_vec(tbl[i]);
      end
      cur_load = tbl[13].exp_load;

      for (int i = 0; i < 200; i++) begin
         tag = $sformatf("rnd%0d", i);
         sel = $urandom_range(0, 9);
         v.ld = (sel < 5); v.st = (sel >= 5 && sel < 9);
         v.addr = $urandom; v.bs = 1'($urandom); v.hws = 1'($urandom);
         v.wdata = $urandom; v.rdata = $urandom;
         v.gnt_wait = $urandom_range(0, 2); v.rv_wait = $urandom_range(0, 3);
         case ($urandom_range(0, 4))
            0: v.strb = 4'($urandom);
            1: v.strb = 4'b0001 << v.addr[1:0];
            2: v.strb = 4'b0011 << v.addr[1:0];
            default: begin
               v.strb = 4'b1111;
               if ($urandom_range(0, 1) == 1) v.addr[1:0] = 2'b00;
            end
         endcase
         spam = 1'($urandom);
         v = model(v, cur_load);
         run_vec(v);
         cur_load = v.exp_load;
      end
      spam = 1'b0;

      tag = "rst_resp";
      IS_LOAD = 1; IS_STORE = 0; DMEM_ADDR = 32'h0000_D000; STRB = 4'b1111; C_MEM = 1'b1;
      step();
      C_MEM = 1'b0;
      check("req_c1", 32'(mem.MEM_REQ), 32'd1);
      mem.MEM_GNT = 1'b1;
      step();
      mem.MEM_GNT = 1'b0;
      check("busy_resp", 32'(BUSY), 32'd1);
      #2 NRST = 1'b0;
      #1 check_zero("async");
      @(negedge CLK);
      NRST = 1'b1;
      done_seen = 0;
      for (int i = 0; i < 4; i++) begin
         mem.MEM_RVALID = 1'b1; mem.MEM_RDATA = 32'hFFFF_FFFF;
         step();
         if (DONE) done_seen++;
      end
      mem.MEM_RVALID = 1'b0;
      check("no_done_after_rst", 32'(done_seen), 32'd0);
      check("load_cleared", LOAD_DATA, 32'd0);

      tag = "fresh_lw";
      v.ld = 1; v.st = 0; v.addr = 32'h0000_D008; v.strb = 4'b1111; v.bs = 0; v.hws = 0;
      v.wdata = 32'h0; v.rdata = 32'hA5C3_0F96; v.gnt_wait = 0; v.rv_wait = 0;
      v = model(v, 32'd0);
      run_vec(v);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
